// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between fetch and decode.
//
// Buffers {pc, instruction, pc_next} triples so fetch keeps running while
// decode is stalled. The head entry is presented first-word-fall-through as
// the IF/ID register contents. A flush (branch/jump redirect) discards every
// buffered entry.
//
// Optional feature macro: FETCH_QUEUE_STATS_EN adds a saturating 16-bit
// drop_count output that accumulates entries discarded by flush.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   f_valid, f_pc,      fetch-side entry (pc, instruction, pc + 4)
//   f_instruction,
//   f_pc_next
//   flush               redirect from decode, kills all queued entries
//   stall               decode stall, head entry is held
//   full                queue holds DEPTH entries (stalls the PC)
//   IF_ID_*             head entry; all data reads 0 when IF_ID_valid = 0
//   count               occupancy 0..DEPTH
//   drop_count          (FETCH_QUEUE_STATS_EN only) entries lost to flush

module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             f_valid,
    input  logic [31:0]      f_pc,
    input  logic [31:0]      f_instruction,
    input  logic [31:0]      f_pc_next,
    input  logic             flush,
    input  logic             stall,
    output logic             full,
    output logic             IF_ID_valid,
    output logic [31:0]      IF_ID_pc,
    output logic [31:0]      IF_ID_instruction,
    output logic [31:0]      IF_ID_pc_next,
`ifdef FETCH_QUEUE_STATS_EN
    output logic [15:0]      drop_count,
`endif
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [31:0] pc_next;
    } entry_t;

    localparam logic [PTR_W:0] DepthCnt = (PTR_W + 1)'(DEPTH);

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              push, pop;
    entry_t            head;

    // Status decoded from registered occupancy only.
    assign full        = (count_q == DepthCnt);
    assign IF_ID_valid = (count_q != '0);
    assign count       = count_q;

    // No push-through when full, even if the head pops this cycle.
    assign push = f_valid & ~full & ~flush;
    assign pop  = IF_ID_valid & ~stall & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (flush) begin
            // Push is already suppressed, so wr_ptr stays and the queue empties.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; contents are only observed when valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pc: f_pc, instruction: f_instruction, pc_next: f_pc_next};
        end
    end

    always_comb begin
        head              = mem_q[rd_ptr_q];
        IF_ID_pc          = IF_ID_valid ? head.pc          : 32'h0;
        IF_ID_instruction = IF_ID_valid ? head.instruction : 32'h0;
        IF_ID_pc_next     = IF_ID_valid ? head.pc_next     : 32'h0;
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [15:0] drop_count_q, drop_count_d;
    logic [16:0] drop_sum;

    always_comb begin
        drop_sum     = {1'b0, drop_count_q} + 17'(count_q);
        drop_count_d = drop_count_q;
        if (flush) begin
            drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue. A scoreboard queue receives each entry
// the bench expects the DUT to accept and is popped when the head should
// leave; each test task compares DUT outputs against it and against constants.

module tb_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcn;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_valid, flush, stall;
    logic [31:0] f_pc, f_instruction, f_pc_next;
    logic        full, IF_ID_valid;
    logic [31:0] IF_ID_pc, IF_ID_instruction, IF_ID_pc_next;
    logic [2:0]  count;
`ifdef FETCH_QUEUE_STATS_EN
    logic [15:0] drop_count;
`endif

    ent_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_drops = 0;
    bit   last_push, last_pop;

    fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .f_valid           (f_valid),
        .f_pc              (f_pc),
        .f_instruction     (f_instruction),
        .f_pc_next         (f_pc_next),
        .flush             (flush),
        .stall             (stall),
        .full              (full),
        .IF_ID_valid       (IF_ID_valid),
        .IF_ID_pc          (IF_ID_pc),
        .IF_ID_instruction (IF_ID_instruction),
        .IF_ID_pc_next     (IF_ID_pc_next),
`ifdef FETCH_QUEUE_STATS_EN
        .drop_count        (drop_count),
`endif
        .count             (count)
    );

    always #5 clk = ~clk;

    task automatic set_in(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                          input bit st, input bit fl);
        f_valid       = v;
        f_pc          = pc;
        f_instruction = instr;
        f_pc_next     = pc + 32'd4;
        stall         = st;
        flush         = fl;
    endtask

    // Updates the scoreboard for the inputs currently driven, then clocks.
    task automatic advance();
        int n;
        ent_t e;
        n = sb.size();
        last_push = f_valid && (n != DEPTH) && !flush;
        last_pop  = (n != 0) && !stall && !flush;
        if (flush) begin
            exp_drops = (exp_drops + n > 65535) ? 65535 : exp_drops + n;
            sb.delete();
        end else begin
            if (last_pop) void'(sb.pop_front());
            if (last_push) begin
                e.pc = f_pc; e.instr = f_instruction; e.pcn = f_pc_next;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_instr(input logic [31:0] pc);
        return {~pc[15:0], pc[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        set_in(0, 32'h0, 32'h0, 0, 0);
        #3;
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL idle_count: got %0d expected 0", count); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL idle_full: got %b expected 0", full); end
        vectors++; if (IF_ID_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid: got %b expected 0", IF_ID_valid); end
        vectors++; if (IF_ID_instruction !== 32'h0) begin miscompares++; $display("FAIL idle_instr: got %h expected 0", IF_ID_instruction); end
        vectors++; if (IF_ID_pc !== 32'h0 || IF_ID_pc_next !== 32'h0) begin miscompares++; $display("FAIL idle_pc: got %h/%h expected 0/0", IF_ID_pc, IF_ID_pc_next); end
`ifdef FETCH_QUEUE_STATS_EN
        vectors++; if (drop_count !== 16'h0) begin miscompares++; $display("FAIL reset_drops: got %0d expected 0", drop_count); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        logic [31:0] instrs [3];
        instrs[0] = 32'h1111_1111; instrs[1] = 32'h2222_2222; instrs[2] = 32'h3333_3333;
        for (int i = 0; i < 5; i++) begin
            set_in(i < 3, 32'(i * 4), (i < 3) ? instrs[i] : 32'h0, 0, 0);
            @(negedge clk);
            vectors++; if (IF_ID_valid !== (i >= 1 && i <= 3)) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b expected %b", i, IF_ID_valid, (i >= 1 && i <= 3)); end
            vectors++; if (count > 3'd1) begin miscompares++; $display("FAIL stream_count[%0d]: got %0d expected <=1", i, count); end
            if (i >= 1 && i <= 3) begin
                vectors++; if (IF_ID_pc !== 32'((i - 1) * 4) || IF_ID_instruction !== instrs[i - 1]) begin miscompares++; $display("FAIL stream_head[%0d]: got %h/%h expected %h/%h", i, IF_ID_pc, IF_ID_instruction, 32'((i - 1) * 4), instrs[i - 1]); end
                vectors++; if (IF_ID_pc_next !== 32'(i * 4)) begin miscompares++; $display("FAIL stream_pcn[%0d]: got %h expected %h", i, IF_ID_pc_next, 32'(i * 4)); end
            end
            advance();
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 32'h10 + 32'(4 * i), gen_instr(32'h10 + 32'(4 * i)), 1, 0);
            @(negedge clk);
            vectors++; if (count !== 3'(i) || full !== 1'b0) begin miscompares++; $display("FAIL fill_count[%0d]: got %0d/%b expected %0d/0", i, count, full, i); end
            advance();
        end
        set_in(1, 32'h20, gen_instr(32'h20), 1, 0);
        @(negedge clk);
        vectors++; if (full !== 1'b1 || count !== 3'd4) begin miscompares++; $display("FAIL full_flag: got %b/%0d expected 1/4", full, count); end
        advance();
        // Release stall while fetch still offers 0x20: pop happens, push must not.
        for (int k = 0; k < 5; k++) begin
            set_in(k == 0, 32'h20, gen_instr(32'h20), 0, 0);
            @(negedge clk);
            vectors++; if (IF_ID_valid !== (k < 4)) begin miscompares++; $display("FAIL drain_valid[%0d]: got %b expected %b", k, IF_ID_valid, (k < 4)); end
            if (k < 4) begin
                vectors++; if (IF_ID_pc !== 32'h10 + 32'(4 * k) || IF_ID_instruction !== gen_instr(32'h10 + 32'(4 * k))) begin miscompares++; $display("FAIL drain_head[%0d]: got %h/%h expected %h", k, IF_ID_pc, IF_ID_instruction, 32'h10 + 32'(4 * k)); end
            end
            advance();
        end
        @(negedge clk);
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL drain_count: got %0d expected 0", count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 32'h40 + 32'(4 * i), gen_instr(32'h40 + 32'(4 * i)), 1, 0);
            advance();
        end
        set_in(1, 32'h50, gen_instr(32'h50), 1, 1);
        @(negedge clk);
        vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL preflush_count: got %0d expected 3", count); end
        advance();
        set_in(0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        vectors++; if (count !== 3'd0 || IF_ID_valid !== 1'b0 || full !== 1'b0) begin miscompares++; $display("FAIL flush_state: got %0d/%b/%b expected 0/0/0", count, IF_ID_valid, full); end
        vectors++; if (IF_ID_instruction !== 32'h0) begin miscompares++; $display("FAIL flush_instr: got %h expected 0", IF_ID_instruction); end
`ifdef FETCH_QUEUE_STATS_EN
        vectors++; if (drop_count !== 16'(exp_drops)) begin miscompares++; $display("FAIL flush_drops: got %0d expected %0d", drop_count, exp_drops); end
`endif
        advance();
        @(negedge clk);
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL flush_nostore: got %0d expected 0", count); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        int pushed = 0;
        int popped = 0;
        logic [31:0] epc;
        for (int cyc = 0; cyc < 200 && popped < 20; cyc++) begin
            set_in(pushed < 20, 32'h100 + 32'(4 * pushed), gen_instr(32'h100 + 32'(4 * pushed)), cyc[0], 0);
            @(negedge clk);
            vectors++; if (IF_ID_valid !== (sb.size() != 0)) begin miscompares++; $display("FAIL wrap_valid[%0d]: got %b expected %b", cyc, IF_ID_valid, (sb.size() != 0)); end
            if (sb.size() != 0) begin
                epc = 32'h100 + 32'(4 * popped);
                vectors++; if (IF_ID_pc !== epc || IF_ID_instruction !== sb[0].instr || IF_ID_pc_next !== epc + 32'd4) begin miscompares++; $display("FAIL wrap_head[%0d]: got %h/%h expected %h/%h", cyc, IF_ID_pc, IF_ID_instruction, epc, sb[0].instr); end
                vectors++; if (sb[0].pc !== epc) begin miscompares++; $display("FAIL wrap_order[%0d]: got %h expected %h", cyc, sb[0].pc, epc); end
            end
            advance();
            if (last_push) pushed++;
            if (last_pop) popped++;
        end
        vectors++; if (popped != 20) begin miscompares++; $display("FAIL wrap_total: got %0d expected 20", popped); end
        @(negedge clk);
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL wrap_end_count: got %0d expected 0", count); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(1, 32'h200 + 32'(4 * i), gen_instr(32'h200 + 32'(4 * i)), 1, 0);
            advance();
        end
        set_in(0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        vectors++; if (count !== 3'd2 || IF_ID_pc !== 32'h200) begin miscompares++; $display("FAIL prereset: got %0d/%h expected 2/00000200", count, IF_ID_pc); end
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (count !== 3'd0 || IF_ID_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset: got %0d/%b expected 0/0", count, IF_ID_valid); end
        vectors++; if (IF_ID_instruction !== 32'h0) begin miscompares++; $display("FAIL async_reset_instr: got %h expected 0", IF_ID_instruction); end
        sb.delete();
        exp_drops = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        set_in(0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        vectors++; if (count !== 3'd0 || full !== 1'b0) begin miscompares++; $display("FAIL post_reset: got %0d/%b expected 0/0", count, full); end
`ifdef FETCH_QUEUE_STATS_EN
        vectors++; if (drop_count !== 16'h0) begin miscompares++; $display("FAIL post_reset_drops: got %0d expected 0", drop_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
